// File: rtl/afu_pkg.sv
// Shared AFU types: cache-line address/data widths and the read-engine state encoding.
package afu_pkg;

  localparam int CL_ADDR_W = 58;
  localparam int CL_DATA_W = 512;

  typedef logic [CL_ADDR_W-1:0] t_cl_addr;
  typedef logic [CL_DATA_W-1:0] t_cl_data;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FIN
  } t_rd_state;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       spl_reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (spl_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; empty/count gate every read, so stale lines are never visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/rd_stream_engine.sv
// Turns a (base, line-count) job into single-line read requests under credit/space limits
// and streams the buffered responses to the core as valid/ready.
module rd_stream_engine
  import afu_pkg::*;
#(
  parameter int FIFO_DEPTH      = 64,
  parameter int MAX_OUTSTANDING = 32,
  parameter int LEN_W           = 32
) (
  input  logic                 clk,
  input  logic                 spl_reset,
  input  logic                 job_start,
  input  logic [CL_ADDR_W-1:0] job_base,
  input  logic [LEN_W-1:0]     job_lines,
  output logic                 busy,
  output logic                 done,
  input  logic                 spl_tx_rd_almostfull,
  output logic                 cor_tx_rd_valid,
  output logic [CL_ADDR_W-1:0] cor_tx_rd_addr,
  output logic [5:0]           cor_tx_rd_len,
  input  logic                 io_rx_rd_valid,
  input  logic [CL_DATA_W-1:0] io_rx_data,
  output logic                 out_valid,
  output logic [CL_DATA_W-1:0] out_data,
  input  logic                 out_ready
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W = ((OUT_W > CNT_W) ? OUT_W : CNT_W) + 1;

  t_rd_state        state;
  t_cl_addr         next_addr;
  logic [LEN_W-1:0] issue_rem;
  logic [LEN_W-1:0] cons_rem;
  logic [OUT_W-1:0] outstanding;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  logic             af_q;
  logic             rsp_accept;
  logic             pop;
  logic             can_issue;
  logic [SUM_W-1:0] reserved;

  // Lines still in flight hold a FIFO slot, so the buffer cannot overflow.
  assign reserved   = SUM_W'(outstanding) + SUM_W'(fifo_count);
  assign can_issue  = (state == ISSUE) && (issue_rem != '0) && !af_q
                   && (outstanding < OUT_W'(MAX_OUTSTANDING))
                   && (reserved < SUM_W'(FIFO_DEPTH));
  assign rsp_accept = io_rx_rd_valid && ((state == ISSUE) || (state == DRAIN));
  assign out_valid  = !fifo_empty;
  assign pop        = out_valid && out_ready;
  assign cor_tx_rd_len = 6'd0;

  sync_fifo #(
    .WIDTH (CL_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .spl_reset (spl_reset),
    .push      (rsp_accept),
    .push_data (io_rx_data),
    .pop       (pop),
    .head      (out_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (spl_reset) begin
      state           <= IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      cor_tx_rd_valid <= 1'b0;
      cor_tx_rd_addr  <= '0;
      next_addr       <= '0;
      issue_rem       <= '0;
      cons_rem        <= '0;
      outstanding     <= '0;
      af_q            <= 1'b0;
    end else begin
      af_q            <= spl_tx_rd_almostfull;
      done            <= 1'b0;
      cor_tx_rd_valid <= can_issue;

      if (can_issue) begin
        cor_tx_rd_addr <= next_addr;
        next_addr      <= next_addr + 1'b1;
        issue_rem      <= issue_rem - 1'b1;
      end

      if (can_issue && !rsp_accept)
        outstanding <= outstanding + 1'b1;
      else if (!can_issue && rsp_accept && (outstanding != '0))
        outstanding <= outstanding - 1'b1;

      if (pop && (cons_rem != '0)) cons_rem <= cons_rem - 1'b1;

      case (state)
        IDLE: begin
          if (job_start) begin
            busy <= 1'b1;
            if (job_lines != '0) begin
              next_addr <= job_base;
              issue_rem <= job_lines;
              cons_rem  <= job_lines;
              state     <= ISSUE;
            end else begin
              state <= FIN;
            end
          end
        end
        ISSUE: begin
          if (can_issue && (issue_rem == LEN_W'(1))) state <= DRAIN;
        end
        DRAIN: begin
          if (cons_rem == '0) state <= FIN;
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rd_stream_engine.sv
// Directed bench for rd_stream_engine: a job table plus hand-written sequences for
// latency, credit stall, FIFO space reservation, almost-full backpressure and mid-job reset.
module tb_rd_stream_engine;

  logic         clk = 1'b0;
  logic         spl_reset;
  logic         job_start;
  logic [57:0]  job_base;
  logic [31:0]  job_lines;
  logic         busy;
  logic         done;
  logic         spl_tx_rd_almostfull;
  logic         cor_tx_rd_valid;
  logic [57:0]  cor_tx_rd_addr;
  logic [5:0]   cor_tx_rd_len;
  logic         io_rx_rd_valid;
  logic [511:0] io_rx_data;
  logic         out_valid;
  logic [511:0] out_data;
  logic         out_ready;

  rd_stream_engine #(
    .FIFO_DEPTH      (8),
    .MAX_OUTSTANDING (4),
    .LEN_W           (32)
  ) dut (
    .clk                  (clk),
    .spl_reset            (spl_reset),
    .job_start            (job_start),
    .job_base             (job_base),
    .job_lines            (job_lines),
    .busy                 (busy),
    .done                 (done),
    .spl_tx_rd_almostfull (spl_tx_rd_almostfull),
    .cor_tx_rd_valid      (cor_tx_rd_valid),
    .cor_tx_rd_addr       (cor_tx_rd_addr),
    .cor_tx_rd_len        (cor_tx_rd_len),
    .io_rx_rd_valid       (io_rx_rd_valid),
    .io_rx_data           (io_rx_data),
    .out_valid            (out_valid),
    .out_data             (out_data),
    .out_ready            (out_ready)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Shared between the monitor, the responder and the main sequence.
  int           cyc          = 0;
  int           req_count    = 0;
  int           done_count   = 0;
  int           len_errs     = 0;
  int           idle_req     = 0;
  int           resp_delay   = 1;
  bit           resp_hold    = 1'b0;
  int           resp_release = 0;
  logic [57:0]  req_log  [$];
  logic [511:0] pop_log  [$];
  logic [57:0]  pend_addr[$];
  int           pend_due [$];

  typedef struct {
    logic [57:0] base;
    int          lines;
    int          exp_reqs;
    logic [57:0] exp_last;
  } vec_t;

  vec_t vecs[5];

  function automatic logic [511:0] data_of(input logic [57:0] a);
    return {8{6'h2A, a}};
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    req_log.delete();
    pop_log.delete();
    req_count = 0;
  endtask

  task automatic start_job(input logic [57:0] base, input int lines);
    job_base  = base;
    job_lines = lines;
    job_start = 1'b1;
    tick();
    job_start = 1'b0;
  endtask

  task automatic run_until_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (done) begin
        seen = 1'b1;
        check("busy_low_with_done", busy, 0);
      end
    end
    check("done_seen", seen, 1);
  endtask

  function automatic int addr_errs(input logic [57:0] base);
    int e = 0;
    for (int i = 0; i < req_log.size(); i++)
      if (req_log[i] !== base + 58'(i)) e++;
    return e;
  endfunction

  function automatic int data_errs(input logic [57:0] base);
    int e = 0;
    for (int i = 0; i < pop_log.size(); i++)
      if (pop_log[i] !== data_of(base + 58'(i))) e++;
    return e;
  endfunction

  // Monitor: samples mid-cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (cor_tx_rd_valid) begin
        req_log.push_back(cor_tx_rd_addr);
        pend_addr.push_back(cor_tx_rd_addr);
        pend_due.push_back(cyc + resp_delay);
        req_count++;
        if (cor_tx_rd_len != 6'd0) len_errs++;
        if (!busy) idle_req++;
      end
      if (out_valid && out_ready) pop_log.push_back(out_data);
      if (done) done_count++;
    end
  end

  // Memory model: returns one line per cycle in request order after resp_delay cycles.
  initial begin
    io_rx_rd_valid = 1'b0;
    io_rx_data     = '0;
    forever begin
      @(posedge clk);
      #1;
      io_rx_rd_valid = 1'b0;
      if (pend_addr.size() > 0 && cyc >= pend_due[0] && (!resp_hold || resp_release > 0)) begin
        if (resp_hold) resp_release--;
        io_rx_rd_valid = 1'b1;
        io_rx_data     = data_of(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dc0;
    int cnt_a;

    vecs[0] = '{base: 58'h100,                lines: 4, exp_reqs: 4, exp_last: 58'h103};
    vecs[1] = '{base: 58'h0,                  lines: 0, exp_reqs: 0, exp_last: 58'h0};
    vecs[2] = '{base: 58'h3FF_FFFF_FFFF_FFFF, lines: 2, exp_reqs: 2, exp_last: 58'h0};
    vecs[3] = '{base: 58'h55,                 lines: 1, exp_reqs: 1, exp_last: 58'h55};
    vecs[4] = '{base: 58'h200,                lines: 9, exp_reqs: 9, exp_last: 58'h208};

    spl_reset            = 1'b1;
    job_start            = 1'b0;
    job_base             = '0;
    job_lines            = '0;
    spl_tx_rd_almostfull = 1'b0;
    out_ready            = 1'b1;
    tick(3);
    check("rst_rd_valid", cor_tx_rd_valid, 0);
    check("rst_rd_addr", cor_tx_rd_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out_valid", out_valid, 0);
    spl_reset = 1'b0;
    tick(2);

    // First-request latency and registered address/len.
    clear_logs();
    resp_delay = 3;
    start_job(58'h100, 4);
    check("lat_busy", busy, 1);
    check("lat_valid_early", cor_tx_rd_valid, 0);
    tick();
    check("lat_valid", cor_tx_rd_valid, 1);
    check("lat_addr", cor_tx_rd_addr, 58'h100);
    check("lat_len", cor_tx_rd_len, 0);
    run_until_done(100);
    check("lat_pops", pop_log.size(), 4);
    check("lat_data", data_errs(58'h100), 0);
    tick(2);

    // Zero-line job: no requests, done two cycles after job_start.
    clear_logs();
    start_job(58'h123, 0);
    check("zero_busy", busy, 1);
    check("zero_done_early", done, 0);
    tick();
    check("zero_done", done, 1);
    check("zero_busy_low", busy, 0);
    tick();
    check("zero_done_once", done, 0);
    check("zero_reqs", req_count, 0);

    // Job table, no backpressure.
    resp_delay = 1;
    for (int v = 0; v < 5; v++) begin
      clear_logs();
      dc0 = done_count;
      start_job(vecs[v].base, vecs[v].lines);
      run_until_done(200);
      tick(3);
      check($sformatf("vec%0d_reqs", v), req_count, vecs[v].exp_reqs);
      if (vecs[v].exp_reqs > 0) begin
        check($sformatf("vec%0d_first", v), req_log[0], vecs[v].base);
        check($sformatf("vec%0d_last", v), req_log[req_log.size()-1], vecs[v].exp_last);
      end
      check($sformatf("vec%0d_pops", v), pop_log.size(), vecs[v].lines);
      check($sformatf("vec%0d_data", v), data_errs(vecs[v].base), 0);
      check($sformatf("vec%0d_done_pulses", v), done_count - dc0, 1);
    end

    // Credit limit: 4 in flight, then exactly one more per released response.
    clear_logs();
    resp_hold = 1'b1;
    start_job(58'h400, 10);
    tick(2);
    start_job(58'h999, 2);
    tick(10);
    check("credit_stall", req_count, 4);
    resp_release = 1;
    tick(10);
    check("credit_one_more", req_count, 5);
    resp_hold = 1'b0;
    run_until_done(300);
    check("credit_reqs", req_count, 10);
    check("credit_addrs", addr_errs(58'h400), 0);
    check("credit_pops", pop_log.size(), 10);
    check("credit_data", data_errs(58'h400), 0);
    tick(2);

    // FIFO space reservation with a stalled consumer.
    clear_logs();
    resp_delay = 0;
    out_ready  = 1'b0;
    start_job(58'h800, 20);
    tick(30);
    check("fifo_reqs_capped", req_count, 8);
    check("fifo_count_full", dut.fifo_count, 8);
    check("fifo_out_valid", out_valid, 1);
    check("fifo_head", out_data, data_of(58'h800));
    out_ready = 1'b1;
    run_until_done(300);
    check("fifo_reqs", req_count, 20);
    check("fifo_pops", pop_log.size(), 20);
    check("fifo_data", data_errs(58'h800), 0);
    tick(2);

    // Almost-full held for 10 cycles mid-job.
    clear_logs();
    resp_delay = 1;
    start_job(58'h1000, 12);
    for (int i = 0; i < 20 && req_count < 3; i++) tick();
    spl_tx_rd_almostfull = 1'b1;
    tick(2);
    cnt_a = req_count;
    tick(8);
    spl_tx_rd_almostfull = 1'b0;
    tick();
    check("af_no_reqs", req_count, cnt_a);
    check("af_mid_job", (cnt_a < 12), 1);
    run_until_done(200);
    check("af_reqs", req_count, 12);
    check("af_addrs", addr_errs(58'h1000), 0);
    check("af_data", data_errs(58'h1000), 0);
    tick(2);

    // Reset mid-job with 3 lines outstanding; late responses must be dropped.
    clear_logs();
    resp_hold = 1'b1;
    start_job(58'h600, 3);
    tick(8);
    check("rstjob_reqs", req_count, 3);
    spl_reset = 1'b1;
    tick();
    check("rstjob_valid", cor_tx_rd_valid, 0);
    check("rstjob_addr", cor_tx_rd_addr, 0);
    check("rstjob_busy", busy, 0);
    check("rstjob_out_valid", out_valid, 0);
    tick();
    spl_reset = 1'b0;
    resp_hold = 1'b0;
    tick(8);
    check("rstjob_drop_valid", out_valid, 0);
    check("rstjob_drop_count", dut.fifo_count, 0);
    check("rstjob_drop_pops", pop_log.size(), 0);
    clear_logs();
    start_job(58'h700, 3);
    run_until_done(100);
    check("rstjob_new_pops", pop_log.size(), 3);
    check("rstjob_new_data", data_errs(58'h700), 0);
    tick(2);

    check("len_always_zero", len_errs, 0);
    check("no_req_when_idle", idle_req, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rd_stream_engine.md
Name: rd_stream_engine

Overview:
- Read-side stream engine between afu_core and afu_io.
- Converts a (base, line-count) job into single-cache-line read requests on the cor_tx_rd_* interface.
- Honours spl_tx_rd_almostfull and a credit limit, buffers io_rx_rd_valid/io_rx_data responses in a FIFO, and presents them to core logic as a valid/ready stream.
- Signals done once every requested line has been consumed.

Parameters:
- FIFO_DEPTH, 64, response buffer depth in 512-bit lines; power of 2, minimum 4.
- MAX_OUTSTANDING, 32, cap on in-flight read requests; must be <= FIFO_DEPTH.
- LEN_W, 32, width of the job line-count.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- spl_reset  in  1  synchronous, active-high reset.
- job_start  in  1  one-cycle job launch; accepted only in IDLE.
- job_base  in  58  cache-line address of the first line (io_src_ptr[63:6]).
- job_lines  in  LEN_W  number of lines to read.
- busy  out  1  high when state != IDLE.
- done  out  1  one-cycle pulse at job completion.
- spl_tx_rd_almostfull  in  1  read-request backpressure.
- cor_tx_rd_valid  out  1  read request strobe.
- cor_tx_rd_addr  out  58  cache-line address of the request.
- cor_tx_rd_len  out  6  always 6'd0 (one line).
- io_rx_rd_valid  in  1  read response strobe.
- io_rx_data  in  512  read response line.
- out_valid  out  1  stream data valid.
- out_data  out  512  stream data (FIFO head).
- out_ready  in  1  consumer accepts the line.

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0, FIFO empty. Reset takes effect mid-job: in-flight responses arriving after reset are discarded (IDLE rule below).
- State IDLE:
  - job_start with job_lines != 0: latch next_addr = job_base, issue_rem = job_lines, cons_rem = job_lines; go to ISSUE.
  - job_start with job_lines == 0: go to FIN.
- State ISSUE: each cycle, cor_tx_rd_valid is registered high when all of:
  - issue_rem != 0
  - !spl_tx_rd_almostfull (as sampled the previous cycle)
  - outstanding < MAX_OUTSTANDING
  - outstanding + fifo_count < FIFO_DEPTH (space reservation, so the FIFO can never overflow)
- On each issue:
  - cor_tx_rd_addr = next_addr.
  - next_addr increments by 1, wrapping modulo 2^58.
  - issue_rem decrements.
  - outstanding increments.
- Go to DRAIN when issue_rem reaches 0.
- State DRAIN: no requests. Go to FIN when cons_rem == 0.
- State FIN: done = 1 for exactly one cycle; go to IDLE next cycle.
- cor_tx_rd_valid is a single-cycle pulse per request and is never asserted outside ISSUE.
- Responses:
  - io_rx_rd_valid pushes io_rx_data into the FIFO and decrements outstanding.
  - An issue and a response in the same cycle leave outstanding unchanged.
  - Responses are delivered in arrival order; no reordering.
- Response in IDLE or FIN: the line is dropped and outstanding is unchanged.
- Stream interface:
  - out_valid = FIFO not empty; out_data = FIFO head (first-word-fall-through).
  - A pop occurs when out_valid && out_ready, and decrements cons_rem.
  - Push and pop in the same cycle leave fifo_count unchanged. A push into an empty FIFO appears on out_valid the next cycle.
- Latency: job_start to first cor_tx_rd_valid is 2 cycles when not backpressured.
- job_start while busy: ignored; latched values are unchanged.
- Counter widths:
  - outstanding: clog2(MAX_OUTSTANDING+1).
  - fifo_count: clog2(FIFO_DEPTH+1).
  - issue_rem and cons_rem: LEN_W, never underflow.

Decomposition:
- Shared package (afu_pkg):
  - localparam CL_ADDR_W = 58, CL_DATA_W = 512.
  - typedef t_cl_addr logic [57:0]; typedef t_cl_data logic [511:0].
  - typedef enum for the states IDLE/ISSUE/DRAIN/FIN.
- Sub-module sync_fifo (parameters WIDTH, DEPTH): FWFT, count output, registered memory, synchronous active-high reset clears pointers. The rd_stream_engine top holds the FSM, credit logic and address generation.

Test Plan:
- job_base = 58'h100, job_lines = 4, no backpressure, responses 3 cycles after each request, out_ready = 1 -> requests to 0x100..0x103 with len 0, 4 lines out in order, one done pulse, busy falls the same cycle as done.
- job_lines = 0 -> no cor_tx_rd_valid; done pulses 2 cycles after job_start.
- MAX_OUTSTANDING = 4, job_lines = 10, responses withheld -> exactly 4 requests, then stall; releasing one response -> exactly one more request.
- FIFO_DEPTH = 8, job_lines = 20, out_ready = 0, immediate responses -> requests stop at 8 total and fifo_count = 8 with no overflow; raising out_ready -> all 20 delivered and done.
- spl_tx_rd_almostfull held high for 10 cycles mid-job -> no requests while asserted (allowing the one-cycle sampling lag), resumes at the correct next address; job_base = 58'h3FF_FFFF_FFFF_FFFF, job_lines = 2 -> addresses wrap to 0.
- spl_reset asserted mid-job with 3 lines outstanding -> outputs 0 and FIFO empty; the 3 late responses are dropped; a new job then completes normally.
